// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a byte stream into little-endian words,
// writes them to addresses 0..Depth-1, and holds the core in reset until the load is complete.
module imem_loader #(
    parameter int Width     = 32,
    parameter int Depth     = 32,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inValid,
    input  logic [7:0]           inData,
    output logic                 inReady,
    output logic                 wrEn,
    output logic [AddrWidth-1:0] addr,
    output logic [Width-1:0]     data,
    output logic [AddrWidth:0]   wordCount,
    input  logic                 restart,
    output logic                 done,
    output logic                 cpuReset
);

    localparam int Bytes = Width / 8;
    localparam int BIdxW = (Bytes > 1) ? $clog2(Bytes) : 1;
    localparam logic [BIdxW-1:0]     LastByte = BIdxW'(Bytes - 1);
    localparam logic [BIdxW-1:0]     BIdxOne  = BIdxW'(1);
    localparam logic [AddrWidth-1:0] LastWord = AddrWidth'(Depth - 1);
    localparam logic [AddrWidth-1:0] WIdxOne  = AddrWidth'(1);
    localparam logic [AddrWidth:0]   CntOne   = (AddrWidth + 1)'(1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [BIdxW-1:0]     r_bidx;
    logic [AddrWidth-1:0] r_widx;
    logic [Width-1:0]     r_asm;
    logic [Width-1:0]     w_word;
    logic [AddrWidth-1:0] r_addr;
    logic [Width-1:0]     r_data;
    logic [AddrWidth:0]   r_count;
    logic                 r_done;
    logic                 r_cpuReset;

    // The incoming byte always completes the top lane when it is the last one of a word.
    always_comb begin
        w_word                 = r_asm;
        w_word[Width-1 -: 8]   = inData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        inReady = 1'b0;
        wrEn    = 1'b0;
        case (r_state)
            S_LOAD: begin
                inReady = !reset;
                if (inValid && (r_bidx == LastByte)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                wrEn   = 1'b1;
                w_next = (r_widx == LastWord) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                if (restart) begin
                    w_next = S_LOAD;
                end
            end
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bidx     <= '0;
            r_widx     <= '0;
            r_asm      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_cpuReset <= 1'b1;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (inValid) begin
                        if (r_bidx == LastByte) begin
                            r_bidx <= '0;
                            r_addr <= r_widx;
                            r_data <= w_word;
                        end else begin
                            r_asm[8*int'(r_bidx) +: 8] <= inData;
                            r_bidx <= r_bidx + BIdxOne;
                        end
                    end
                end
                S_WRITE: begin
                    r_count <= r_count + CntOne;
                    r_asm   <= '0;
                    if (r_widx == LastWord) begin
                        r_done     <= 1'b1;
                        r_cpuReset <= 1'b0;
                    end else begin
                        r_widx <= r_widx + WIdxOne;
                    end
                end
                S_DONE: begin
                    // addr/data keep the last written word so the memory port stays quiet.
                    if (restart) begin
                        r_widx     <= '0;
                        r_bidx     <= '0;
                        r_count    <= '0;
                        r_done     <= 1'b0;
                        r_cpuReset <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign addr      = r_addr;
    assign data      = r_data;
    assign wordCount = r_count;
    assign done      = r_done;
    assign cpuReset  = r_cpuReset;

endmodule
